// File: rtl/lcd_panel_model.sv
// Responder for a dual-controller 128x64 KS0108-style LCD bus: decodes driver transactions per half,
// holds the 1 KiB display RAM, answers status/data reads and offers a registered pixel viewer port.
module lcd_panel_model #(
  parameter int unsigned BUSY_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  db_i,
  input  logic        dori_i,
  input  logic [1:0]  cs_i,
  input  logic        en_i,
  input  logic        rw_i,
  input  logic        rst_i,
  output logic [7:0]  db_o,
  output logic        db_oe_o,
  input  logic [9:0]  rd_addr_i,
  output logic [7:0]  rd_data_o,
  output logic [1:0]  disp_on_o,
  output logic [11:0] start_line_o,
  output logic        frame_evt_o,
  output logic        proto_err_o
);

  localparam int unsigned BW = (BUSY_CYCLES < 2) ? 1 : $clog2(BUSY_CYCLES + 1);
  localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES);

  logic          en_q;
  logic [7:0]    db_q;
  logic          dori_q;
  logic          rw_q;
  logic [1:0]    cs_q;

  logic [2:0]    page_q  [2];
  logic [2:0]    page_d  [2];
  logic [5:0]    y_q     [2];
  logic [5:0]    y_d     [2];
  logic [7:0]    latch_q [2];
  logic [7:0]    latch_d [2];
  logic [BW-1:0] busy_q  [2];
  logic [BW-1:0] busy_d  [2];
  logic [5:0]    start_q [2];
  logic [5:0]    start_d [2];
  logic [1:0]    disp_q;
  logic [1:0]    disp_d;
  logic          frame_q;
  logic          frame_d;
  logic          perr_q;
  logic          perr_d;
  logic [7:0]    rdData_q;

  logic [7:0]    ramL [512];
  logic [7:0]    ramR [512];
  logic [7:0]    ramRd [2];
  logic [1:0]    wen;
  logic          fall;

  assign fall     = en_q & ~en_i;
  assign ramRd[0] = ramL[{page_q[0], y_q[0]}];
  assign ramRd[1] = ramR[{page_q[1], y_q[1]}];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q     <= 1'b0;
      db_q     <= '0;
      dori_q   <= 1'b0;
      rw_q     <= 1'b0;
      cs_q     <= '0;
      disp_q   <= '0;
      frame_q  <= 1'b0;
      perr_q   <= 1'b0;
      rdData_q <= '0;
      for (int h = 0; h < 2; h++) begin
        page_q[h]  <= '0;
        y_q[h]     <= '0;
        latch_q[h] <= '0;
        busy_q[h]  <= '0;
        start_q[h] <= '0;
      end
    end else begin
      en_q     <= en_i;
      db_q     <= db_i;
      dori_q   <= dori_i;
      rw_q     <= rw_i;
      cs_q     <= cs_i;
      disp_q   <= disp_d;
      frame_q  <= frame_d;
      perr_q   <= perr_d;
      rdData_q <= rd_addr_i[9] ? ramR[rd_addr_i[8:0]] : ramL[rd_addr_i[8:0]];
      for (int h = 0; h < 2; h++) begin
        page_q[h]  <= page_d[h];
        y_q[h]     <= y_d[h];
        latch_q[h] <= latch_d[h];
        busy_q[h]  <= busy_d[h];
        start_q[h] <= start_d[h];
      end
    end
  end

  // RAM has no reset; nonblocking writes give the viewer the old byte on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (wen[0]) ramL[{page_q[0], y_q[0]}] <= db_q;
    if (wen[1]) ramR[{page_q[1], y_q[1]}] <= db_q;
  end

  always_comb begin
    page_d  = page_q;
    y_d     = y_q;
    latch_d = latch_q;
    busy_d  = busy_q;
    start_d = start_q;
    disp_d  = disp_q;
    frame_d = 1'b0;
    perr_d  = perr_q;
    wen     = '0;
    for (int h = 0; h < 2; h++) begin
      if (busy_q[h] != '0) busy_d[h] = busy_q[h] - BW'(1);
      if (rst_i) begin
        page_d[h]  = '0;
        y_d[h]     = '0;
        busy_d[h]  = '0;
        start_d[h] = '0;
        disp_d[h]  = 1'b0;
      end else if (fall && cs_q[h]) begin
        if (!rw_q) begin
          busy_d[h] = BUSY_LOAD;
          if (busy_q[h] != '0) perr_d = 1'b1;
        end
        case ({rw_q, dori_q})
          2'b00: begin
            if (db_q[7:1] == 7'b0011111) begin
              disp_d[h] = db_q[0];
              if (db_q[0]) frame_d = 1'b1;
            end else if (db_q[7:6] == 2'b01) begin
              y_d[h] = db_q[5:0];
            end else if (db_q[7:3] == 5'b10111) begin
              page_d[h] = db_q[2:0];
            end else if (db_q[7:6] == 2'b11) begin
              start_d[h] = db_q[5:0];
            end
          end
          2'b01: begin
            wen[h] = 1'b1;
            y_d[h] = y_q[h] + 6'd1;
          end
          // Dummy-read: the driver already saw the old latch; refill it for the next read.
          2'b11: begin
            latch_d[h] = ramRd[h];
            y_d[h]     = y_q[h] + 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

  logic       srcSel;
  logic [7:0] statusByte;

  always_comb begin
    srcSel     = ~cs_i[0];
    statusByte = {(busy_q[srcSel] != '0), 1'b0, ~disp_q[srcSel], rst_i, 4'b0000};
    db_oe_o    = en_i & rw_i & (cs_i != 2'b00);
    db_o       = 8'h00;
    if (db_oe_o) db_o = dori_i ? latch_q[srcSel] : statusByte;
  end

  assign rd_data_o    = rdData_q;
  assign disp_on_o    = disp_q;
  assign start_line_o = {start_q[1], start_q[0]};
  assign frame_evt_o  = frame_q;
  assign proto_err_o  = perr_q;

endmodule

// File: tb/tb_lcd_panel_model.sv
// Directed bench for lcd_panel_model: bus transactions against hand-computed RAM, latch and flag values.
module tb_lcd_panel_model;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  db_i;
  logic        dori_i;
  logic [1:0]  cs_i;
  logic        en_i;
  logic        rw_i;
  logic        rst_i;
  logic [7:0]  db_o;
  logic        db_oe_o;
  logic [9:0]  rd_addr_i;
  logic [7:0]  rd_data_o;
  logic [1:0]  disp_on_o;
  logic [11:0] start_line_o;
  logic        frame_evt_o;
  logic        proto_err_o;

  int errors = 0;
  int checks = 0;
  int frameCount = 0;
  logic [7:0] rdSample;
  logic       oeSample;

  lcd_panel_model #(.BUSY_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn), .db_i(db_i), .dori_i(dori_i), .cs_i(cs_i),
    .en_i(en_i), .rw_i(rw_i), .rst_i(rst_i), .db_o(db_o), .db_oe_o(db_oe_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .disp_on_o(disp_on_o),
    .start_line_o(start_line_o), .frame_evt_o(frame_evt_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_evt_o === 1'b1) frameCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // gap idle cycles, then one bus cycle; returns 1 time unit after the executing clock edge.
  task automatic applyStimulus(input int gap, input logic [1:0] cs, input logic dori,
                               input logic rw, input logic [7:0] data);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    cs_i = cs; dori_i = dori; rw_i = rw; db_i = data; en_i = 1'b1;
    @(posedge clk); #1;
    rdSample = db_o; oeSample = db_oe_o;
    en_i = 1'b0;
    @(posedge clk); #1;
    cs_i = 2'b00; rw_i = 1'b0; dori_i = 1'b0; db_i = 8'h00;
  endtask

  task automatic wr(input logic [1:0] cs, input logic dori, input logic [7:0] data);
    applyStimulus(5, cs, dori, 1'b0, data);
  endtask

  task automatic view(input string tag, input logic [9:0] addr, input logic [7:0] expected);
    @(posedge clk); #1;
    rd_addr_i = addr;
    @(posedge clk); #1;
    checkOutput(tag, {24'd0, rd_data_o}, {24'd0, expected});
  endtask

  initial begin
    rstn = 1'b0; db_i = 8'h00; dori_i = 1'b0; cs_i = 2'b00; en_i = 1'b0;
    rw_i = 1'b0; rst_i = 1'b0; rd_addr_i = 10'd0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset asserted in the middle of a data write.
    @(posedge clk); #1;
    cs_i = 2'b01; dori_i = 1'b1; db_i = 8'hEE; en_i = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checkOutput("rst_db_o", {24'd0, db_o}, 32'h0);
    checkOutput("rst_db_oe", {31'd0, db_oe_o}, 32'h0);
    checkOutput("rst_rd_data", {24'd0, rd_data_o}, 32'h0);
    checkOutput("rst_disp_on", {30'd0, disp_on_o}, 32'h0);
    checkOutput("rst_start_line", {20'd0, start_line_o}, 32'h0);
    checkOutput("rst_frame_evt", {31'd0, frame_evt_o}, 32'h0);
    checkOutput("rst_proto_err", {31'd0, proto_err_o}, 32'h0);
    en_i = 1'b0; cs_i = 2'b00; dori_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    wr(2'b01, 1'b1, 8'h5A);
    checkOutput("write_oe_low", {31'd0, oeSample}, 32'h0);
    view("first_write_ram0", 10'h000, 8'h5A);

    // CS1: y=5, page=2, two data bytes.
    wr(2'b01, 1'b0, 8'h45);
    wr(2'b01, 1'b0, 8'hBA);
    wr(2'b01, 1'b1, 8'hA5);
    wr(2'b01, 1'b1, 8'h3C);
    view("cs1_ram085", 10'h085, 8'hA5);
    view("cs1_ram086", 10'h086, 8'h3C);
    view("cs1_ram000_kept", 10'h000, 8'h5A);

    // CS2: y wraps 63->0 while page stays 7.
    wr(2'b10, 1'b0, 8'h7F);
    wr(2'b10, 1'b0, 8'hBF);
    wr(2'b10, 1'b1, 8'h11);
    wr(2'b10, 1'b1, 8'h22);
    wr(2'b10, 1'b1, 8'h33);
    view("wrap_ram3ff", 10'h3FF, 8'h11);
    view("wrap_ram3c0", 10'h3C0, 8'h22);
    view("wrap_page_kept", 10'h3C1, 8'h33);

    // Dummy read on CS1.
    wr(2'b01, 1'b0, 8'h45);
    wr(2'b01, 1'b0, 8'hBA);
    applyStimulus(5, 2'b01, 1'b1, 1'b1, 8'h00);
    checkOutput("dummy_read_oe", {31'd0, oeSample}, 32'h1);
    checkOutput("dummy_read_stale", {24'd0, rdSample}, 32'h00);
    applyStimulus(5, 2'b01, 1'b1, 1'b1, 8'h00);
    checkOutput("dummy_read_second", {24'd0, rdSample}, 32'hA5);
    wr(2'b01, 1'b1, 8'h77);
    view("dummy_read_y7", 10'h087, 8'h77);

    // Display on both halves, start line, status bytes.
    wr(2'b11, 1'b0, 8'h3F);
    checkOutput("frame_evt_pulse", {31'd0, frame_evt_o}, 32'h1);
    checkOutput("disp_on_both", {30'd0, disp_on_o}, 32'h3);
    @(posedge clk); #1;
    checkOutput("frame_evt_clear", {31'd0, frame_evt_o}, 32'h0);
    checkOutput("frame_count_one", frameCount, 32'd1);
    wr(2'b11, 1'b0, 8'hC8);
    checkOutput("start_line", {20'd0, start_line_o}, 32'h208);
    applyStimulus(5, 2'b01, 1'b0, 1'b1, 8'h00);
    checkOutput("status_on", {24'd0, rdSample}, 32'h00);
    wr(2'b01, 1'b0, 8'h3E);
    checkOutput("disp_on_cs2_only", {30'd0, disp_on_o}, 32'h2);
    applyStimulus(5, 2'b01, 1'b0, 1'b1, 8'h00);
    checkOutput("status_cs1_off", {24'd0, rdSample}, 32'h20);
    applyStimulus(5, 2'b10, 1'b0, 1'b1, 8'h00);
    checkOutput("status_cs2_on", {24'd0, rdSample}, 32'h00);

    // Busy window: back-to-back writes flag a protocol error.
    checkOutput("proto_err_idle", {31'd0, proto_err_o}, 32'h0);
    wr(2'b01, 1'b0, 8'h40);
    applyStimulus(0, 2'b01, 1'b0, 1'b0, 8'h40);
    checkOutput("proto_err_set", {31'd0, proto_err_o}, 32'h1);
    applyStimulus(0, 2'b01, 1'b0, 1'b1, 8'h00);
    checkOutput("status_busy", {24'd0, rdSample}, 32'hA0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("proto_err_sticky", {31'd0, proto_err_o}, 32'h1);

    // Panel reset: flags cleared, RAM kept, coincident transaction dropped.
    @(posedge clk); #1;
    rst_i = 1'b1;
    applyStimulus(2, 2'b11, 1'b0, 1'b0, 8'h3F);
    checkOutput("rst_i_dropped_disp", {30'd0, disp_on_o}, 32'h0);
    applyStimulus(0, 2'b01, 1'b0, 1'b1, 8'h00);
    checkOutput("status_in_rst", {24'd0, rdSample}, 32'h30);
    rst_i = 1'b0;
    checkOutput("rst_i_start_line", {20'd0, start_line_o}, 32'h0);
    checkOutput("rst_i_frame_count", frameCount, 32'd1);
    view("rst_i_ram085", 10'h085, 8'hA5);
    view("rst_i_ram3ff", 10'h3FF, 8'h11);
    wr(2'b01, 1'b1, 8'h99);
    view("rst_i_page_y_zero", 10'h000, 8'h99);

    // Short pattern burst on CS1 page 5 starting at y=10.
    wr(2'b01, 1'b0, 8'hBD);
    wr(2'b01, 1'b0, 8'h4A);
    for (int i = 0; i < 8; i++) wr(2'b01, 1'b1, 8'(i * 17 + 1));
    for (int i = 0; i < 8; i++) view("burst", 10'(10'h14A + i), 8'(i * 17 + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
